alu_core: RTL and testbench

Combinational-result, registered-output 8-bit arithmetic/logic unit for the 6502-compatible CPU core. It sits between the data bus, which supplies its two operand inputs, and the STAT register, which supplies flags. The decoder drives an operation code. One clock after an operation is presented, it returns a result byte, an updated status byte and a one-cycle done strobe.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_adder.sv | 60 ++++++
 rtl/alu_core.sv | 126 ++++++++++++
 tb/tb_alu_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 6502-compatible ALU: operation codes, status bit
// positions and the datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [7:0] ALU_ADC = 8'h01;
  localparam logic [7:0] ALU_SBC = 8'h02;
  localparam logic [7:0] ALU_AND = 8'h03;
  localparam logic [7:0] ALU_ORA = 8'h04;
  localparam logic [7:0] ALU_EOR = 8'h05;
  localparam logic [7:0] ALU_ASL = 8'h06;
  localparam logic [7:0] ALU_LSR = 8'h07;
  localparam logic [7:0] ALU_ROL = 8'h08;
  localparam logic [7:0] ALU_ROR = 8'h09;
  localparam logic [7:0] ALU_INC = 8'h0A;
  localparam logic [7:0] ALU_DEC = 8'h0B;
  localparam logic [7:0] ALU_CMP = 8'h0C;
  localparam logic [7:0] ALU_BIT = 8'h0D;

  localparam int CARRY    = 0;
  localparam int ZERO     = 1;
  localparam int IRQ      = 2;
  localparam int DECIMAL  = 3;
  localparam int BRK      = 4;
  localparam int OVERFLOW = 6;
  localparam int NEGATIVE = 7;

endpackage

// File: rtl/alu_adder.sv
// 8-bit adder with carry-in shared by ADC/SBC/CMP/INC/DEC. Packed-BCD adjust
// is compiled in only when ALU_DECIMAL_EN is defined.
module alu_adder
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] x,
  input  logic [ALU_WIDTH-1:0] y,
  input  logic                 cin,
  input  logic                 dec,
  input  logic                 sub,
  output logic [ALU_WIDTH-1:0] sum,
  output logic [ALU_WIDTH-1:0] bin,
  output logic                 cout,
  output logic                 ovf
);

  logic [ALU_WIDTH:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{ALU_WIDTH{1'b0}}, cin};
  assign bin  = full[ALU_WIDTH-1:0];
  assign ovf  = (x[ALU_WIDTH-1] == y[ALU_WIDTH-1]) && (full[ALU_WIDTH-1] != x[ALU_WIDTH-1]);

`ifdef ALU_DECIMAL_EN
  logic [4:0] lo;
  logic [4:0] hi;
  logic       hc;

  // For subtraction y arrives already inverted, so the nibble carries are
  // "no borrow" and the correction is a subtract-6 when a borrow occurred.
  always_comb begin
    lo   = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, cin};
    hi   = '0;
    hc   = 1'b0;
    sum  = full[ALU_WIDTH-1:0];
    cout = full[ALU_WIDTH];
    if (dec && !sub) begin
      if (lo > 5'd9) lo = lo + 5'd6;
      hc = lo[4];
      hi = {1'b0, x[7:4]} + {1'b0, y[7:4]} + {4'd0, hc};
      if (hi > 5'd9) hi = hi + 5'd6;
      cout = hi[4];
      sum  = {hi[3:0], lo[3:0]};
    end else if (dec && sub) begin
      hc = lo[4];
      if (!hc) lo = lo - 5'd6;
      hi = {1'b0, x[7:4]} + {1'b0, y[7:4]} + {4'd0, hc};
      cout = hi[4];
      if (!cout) hi = hi - 5'd6;
      sum = {hi[3:0], lo[3:0]};
    end
  end
`else
  logic unused_dec;

  assign unused_dec = dec ^ sub;
  assign sum        = full[ALU_WIDTH-1:0];
  assign cout       = full[ALU_WIDTH];
`endif

endmodule

// File: rtl/alu_core.sv
// Registered-output 8-bit 6502 ALU. Define ALU_DECIMAL_EN to honour the D flag
// (packed-BCD ADC/SBC); otherwise ADC/SBC are always binary.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       func,
  input  logic [WIDTH-1:0] status_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dout,
  output logic             wout,
  output logic [WIDTH-1:0] status_out
);

  // No back-pressure: every non-NOP func seen at a rising edge is accepted and
  // completed at that edge; wout is high for the cycle following each one.

  logic [WIDTH-1:0] add_y, add_sum, add_bin;
  logic             add_c, add_dec, add_sub, add_cout, add_ovf;
  logic [WIDTH-1:0] next_dout, next_status, zn_src;
  logic             next_wout, update_zn;

  always_comb begin
    add_y   = b;
    add_c   = status_in[CARRY];
    add_sub = 1'b0;
    case (func)
      ALU_SBC: begin add_y = ~b; add_sub = 1'b1; end
      ALU_CMP: begin add_y = ~b; add_c = 1'b1; end
      ALU_INC: begin add_y = '0; add_c = 1'b1; end
      ALU_DEC: begin add_y = '1; add_c = 1'b0; end
      default: ;
    endcase
    add_dec = status_in[DECIMAL] && ((func == ALU_ADC) || (func == ALU_SBC));
  end

  alu_adder u_adder (
    .x    (a),
    .y    (add_y),
    .cin  (add_c),
    .dec  (add_dec),
    .sub  (add_sub),
    .sum  (add_sum),
    .bin  (add_bin),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  always_comb begin
    next_dout   = dout;
    next_status = status_in;
    next_wout   = 1'b1;
    zn_src      = '0;
    update_zn   = 1'b1;
    case (func)
      ALU_ADC, ALU_SBC: begin
        next_dout             = add_sum;
        next_status[CARRY]    = add_cout;
        next_status[OVERFLOW] = add_ovf;
        zn_src                = add_bin;
      end
      ALU_AND: begin next_dout = a & b; zn_src = next_dout; end
      ALU_ORA: begin next_dout = a | b; zn_src = next_dout; end
      ALU_EOR: begin next_dout = a ^ b; zn_src = next_dout; end
      ALU_ASL: begin
        next_dout          = {a[WIDTH-2:0], 1'b0};
        next_status[CARRY] = a[WIDTH-1];
        zn_src             = next_dout;
      end
      ALU_LSR: begin
        next_dout          = {1'b0, a[WIDTH-1:1]};
        next_status[CARRY] = a[0];
        zn_src             = next_dout;
      end
      ALU_ROL: begin
        next_dout          = {a[WIDTH-2:0], status_in[CARRY]};
        next_status[CARRY] = a[WIDTH-1];
        zn_src             = next_dout;
      end
      ALU_ROR: begin
        next_dout          = {status_in[CARRY], a[WIDTH-1:1]};
        next_status[CARRY] = a[0];
        zn_src             = next_dout;
      end
      ALU_INC, ALU_DEC: begin next_dout = add_bin; zn_src = add_bin; end
      ALU_CMP: begin
        next_dout          = a;
        next_status[CARRY] = add_cout;
        zn_src             = add_bin;
      end
      ALU_BIT: begin
        next_dout             = a;
        update_zn             = 1'b0;
        next_status[ZERO]     = ((a & b) == '0);
        next_status[NEGATIVE] = b[7];
        next_status[OVERFLOW] = b[6];
      end
      default: begin
        next_status = status_out;
        next_wout   = 1'b0;
        update_zn   = 1'b0;
      end
    endcase
    if (update_zn) begin
      next_status[ZERO]     = (zn_src == '0);
      next_status[NEGATIVE] = zn_src[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      status_out <= '0;
      wout       <= 1'b0;
    end else begin
      dout       <= next_dout;
      status_out <= next_status;
      wout       <= next_wout;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases followed by randomized
// operations compared against an arithmetic reference model.
module tb_alu_core;

  logic       clk;
  logic       reset;
  logic [7:0] func;
  logic [7:0] status_in;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] dout;
  logic       wout;
  logic [7:0] status_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [16:0] exp_q[$];
  logic [7:0]  mdl_dout;
  logic [7:0]  mdl_status;

  alu_core dut (
    .clk        (clk),
    .reset      (reset),
    .func       (func),
    .status_in  (status_in),
    .a          (a),
    .b          (b),
    .dout       (dout),
    .wout       (wout),
    .status_out (status_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int signed8(input logic [7:0] v);
    return (v > 8'd127) ? int'(v) - 256 : int'(v);
  endfunction

  // Reference model: returns {wout, dout, status}.
  function automatic logic [16:0] model(input logic [7:0] f, input logic [7:0] st,
                                        input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] pd, input logic [7:0] ps);
    int         c, sum, sr, dv;
    logic [7:0] s, r, d;
    s = st;
    c = int'(st[0]);
    r = 8'h00;
    d = 8'h00;
    dv = 0;
    if (f == 8'h00 || f > 8'h0D) return {1'b0, pd, ps};
    case (f)
      8'h01: begin
        sum = int'(x) + int'(y) + c;
        r = sum[7:0];
        s[0] = (sum > 255);
        sr = signed8(x) + signed8(y) + c;
        s[6] = (sr > 127) || (sr < -128);
      end
      8'h02: begin
        sum = int'(x) - int'(y) - (1 - c);
        r = sum[7:0];
        s[0] = (sum >= 0);
        sr = signed8(x) - signed8(y) - (1 - c);
        s[6] = (sr > 127) || (sr < -128);
      end
      8'h03: r = x & y;
      8'h04: r = x | y;
      8'h05: r = x ^ y;
      8'h06: begin sum = int'(x) * 2; r = sum[7:0]; s[0] = (x >= 8'd128); end
      8'h07: begin r = x / 8'd2; s[0] = x[0]; end
      8'h08: begin sum = int'(x) * 2 + c; r = sum[7:0]; s[0] = (x >= 8'd128); end
      8'h09: begin sum = int'(x) / 2 + 128 * c; r = sum[7:0]; s[0] = x[0]; end
      8'h0A: begin sum = int'(x) + 1; r = sum[7:0]; end
      8'h0B: begin sum = int'(x) + 255; r = sum[7:0]; end
      8'h0C: begin sum = int'(x) - int'(y); r = sum[7:0]; s[0] = (x >= y); end
      default: ;
    endcase
    d = r;
`ifdef ALU_DECIMAL_EN
    if (st[3] && f == 8'h01) begin
      dv = bcd2int(x) + bcd2int(y) + c;
      s[0] = (dv > 99);
      d = int2bcd(dv % 100);
    end else if (st[3] && f == 8'h02) begin
      dv = bcd2int(x) - bcd2int(y) - (1 - c);
      s[0] = (dv >= 0);
      d = int2bcd((dv + 100) % 100);
    end
`endif
    if (f == 8'h0C) d = x;
    if (f == 8'h0D) begin
      d = x;
      s[1] = ((x & y) == 8'h00);
      s[7] = y[7];
      s[6] = y[6];
    end else begin
      s[1] = (r == 8'h00);
      s[7] = r[7];
    end
    return {1'b1, d, s};
  endfunction

  // driver: present one operation, clock it, score against the model
  task automatic step(input string tag, input logic [7:0] f, input logic [7:0] st,
                      input logic [7:0] x, input logic [7:0] y);
    logic [16:0] e;
    func = f;
    status_in = st;
    a = x;
    b = y;
    exp_q.push_back(model(f, st, x, y, mdl_dout, mdl_status));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    mdl_dout   = e[15:8];
    mdl_status = e[7:0];
    check({tag, "_wout"},   32'(wout),       32'(e[16]));
    check({tag, "_dout"},   32'(dout),       32'(e[15:8]));
    check({tag, "_status"}, 32'(status_out), 32'(e[7:0]));
  endtask

  initial begin
    int         k;
    logic [7:0] f, st, x, y;
    reset = 1'b1;
    func = 8'h00;
    status_in = 8'h00;
    a = 8'h00;
    b = 8'h00;
    mdl_dout = 8'h00;
    mdl_status = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_status", 32'(status_out), 32'h00);
    check("rst_wout", 32'(wout), 32'h0);
    reset = 1'b0;

    // directed cases with hard-coded expectations alongside the model
    step("adc_50_50", 8'h01, 8'h00, 8'h50, 8'h50);
    check("adc_50_50_hard", 32'({dout, status_out}), 32'h00A0C0);
    step("nop_after_adc", 8'h00, 8'h00, 8'h12, 8'h34);
    check("nop_hold_hard", 32'({wout, dout}), 32'h0A0);
    step("adc_ff_01", 8'h01, 8'h00, 8'hFF, 8'h01);
    check("adc_ff_01_hard", 32'({dout, status_out}), 32'h000003);
    step("sbc_00_01", 8'h02, 8'h01, 8'h00, 8'h01);
    check("sbc_00_01_hard", 32'({dout, status_out}), 32'h00FF80);
    step("asl_81", 8'h06, 8'h00, 8'h81, 8'h00);
    check("asl_81_hard", 32'({dout, status_out[0]}), 32'h005);
    step("ror_01", 8'h09, 8'h00, 8'h01, 8'h00);
    check("ror_01_hard", 32'({dout, status_out}), 32'h000003);
    step("inc_ff", 8'h0A, 8'h01, 8'hFF, 8'h00);
    check("inc_ff_hard", 32'({dout, status_out}), 32'h000003);
    step("and_f0_0f", 8'h03, 8'h00, 8'hF0, 8'h0F);
    step("cmp_10_10", 8'h0C, 8'h00, 8'h10, 8'h10);
    check("cmp_10_10_hard", 32'({dout, status_out}), 32'h001003);
    step("bit_c0", 8'h0D, 8'h3C, 8'h0F, 8'hC0);
    step("hold_inc_1", 8'h0A, 8'h00, 8'h10, 8'h00);
    step("hold_inc_2", 8'h0A, 8'h00, 8'h11, 8'h00);
    step("nop_code_ff", 8'hFF, 8'hFF, 8'hAA, 8'h55);
`ifdef ALU_DECIMAL_EN
    step("adc_bcd_09_01", 8'h01, 8'h08, 8'h09, 8'h01);
    check("adc_bcd_hard", 32'({dout, status_out[0]}), 32'h020);
`endif

    // reset in the middle of an ADC
    step("adc_pre_rst", 8'h01, 8'h00, 8'h50, 8'h50);
    func = 8'h01;
    a = 8'h40;
    b = 8'h40;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_dout", 32'(dout), 32'h00);
    check("midrst_status", 32'(status_out), 32'h00);
    check("midrst_wout", 32'(wout), 32'h0);
    func = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_dout = 8'h00;
    mdl_status = 8'h00;
    step("post_rst_nop", 8'h00, 8'h00, 8'h00, 8'h00);

    // randomized operations
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 15);
      f = (k <= 13) ? 8'(k) : 8'($urandom_range(14, 255));
      st = 8'($urandom_range(0, 255));
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
`ifdef ALU_DECIMAL_EN
      if (st[3] && (f == 8'h01 || f == 8'h02)) begin
        x = 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
        y = 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
      end
`endif
      step("rand", f, st, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
